irq_controller: RTL and testbench

//  Interrupt source front-end for the j1 core. Synchronises 8 asynchronous

---
 rtl/irq_controller_if.sv | 12 +
 rtl/irq_controller.sv | 143 ++++++++++++++
 tb/tb_irq_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// IO-port bus between the j1 core (master) and the interrupt controller (slave).
// Carries the core's address, strobes and data in both directions.
interface irq_controller_if;
    logic [15:0] io_addr;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    modport master (output io_addr, io_wr, io_rd, io_wdata, input io_rdata);
    modport slave  (input io_addr, io_wr, io_rd, io_wdata, output io_rdata);
endinterface

// File: rtl/irq_controller.sv
// Interrupt front-end for the j1 core: sync + edge detect, pending/mask, one-hot request.
// Define IRQ_TIMER_EN to replace source 7 with an internal 16-bit periodic timer.
module irq_controller #(
    parameter logic [15:0] ADDR_BASE   = 16'h0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic [7:0]       irq_in,
    output logic [7:0]       int_rqst,
    irq_controller_if.slave  io
);
    typedef enum logic [3:0] {
        OFS_PENDING = 4'h0,
        OFS_MASK    = 4'h2,
        OFS_FORCE   = 4'h4,
        OFS_RELOAD  = 4'h6,
        OFS_COUNT   = 4'h8
    } reg_ofs_e;

    logic       hit;
    logic [3:0] ofs;
    logic       wr_pending, wr_mask, wr_force;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_dly_q;
    logic [7:0] edge_raw, src_edge;
    logic [7:0] pending_q, pending_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] active;

    assign hit        = io.io_addr[15:4] == ADDR_BASE[15:4];
    assign ofs        = io.io_addr[3:0];
    assign wr_pending = hit && io.io_wr && (ofs == OFS_PENDING);
    assign wr_mask    = hit && io.io_wr && (ofs == OFS_MASK);
    assign wr_force   = hit && io.io_wr && (ofs == OFS_FORCE);

    always_ff @(posedge clk or negedge resetq) begin
        // NOTE: the synchroniser array is a handful of flops, so clearing it in reset is deliberate.
        if (!resetq) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            sync_dly_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_raw = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

`ifdef IRQ_TIMER_EN
    logic        wr_reload;
    logic        timer_fire;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic        unused_bits;

    assign wr_reload   = hit && io.io_wr && (ofs == OFS_RELOAD);
    assign timer_fire  = !wr_reload && (reload_q != 16'd0) && (count_q == 16'd1);
    assign src_edge    = {timer_fire, edge_raw[6:0]};
    assign unused_bits = ^{io.io_rd, edge_raw[7]};

    always_comb begin
        reload_d = reload_q;
        count_d  = count_q;
        if (wr_reload) begin
            reload_d = io.io_wdata;
            count_d  = io.io_wdata;
        end else if (reload_q == 16'd0) begin
            count_d = '0;
        end else if (count_q <= 16'd1) begin
            count_d = reload_q;
        end else begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            reload_q <= '0;
            count_q  <= '0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
        end
    end
`else
    logic unused_bits;

    assign src_edge    = edge_raw;
    assign unused_bits = ^{io.io_rd, io.io_wdata[15:8]};
`endif

    // Sets (edge, FORCE) are OR-ed in after the W1C so a same-cycle set always wins.
    always_comb begin
        pending_d = pending_q;
        mask_d    = mask_q;
        if (wr_pending) pending_d = pending_d & ~io.io_wdata[7:0];
        pending_d = pending_d | src_edge;
        if (wr_force) pending_d = pending_d | io.io_wdata[7:0];
        if (wr_mask) mask_d = io.io_wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetq) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!resetq) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign active = pending_q & mask_q;

    // Ascending scan: the last hit is the highest set bit, leaving one-hot.
    always_comb begin
        // NOTE: defaults first in every always_comb so no path can infer a latch.
        int_rqst = '0;
        for (int i = 0; i < 8; i++) begin
            if (active[i]) begin
                int_rqst    = '0;
                int_rqst[i] = 1'b1;
            end
        end
    end

    always_comb begin
        io.io_rdata = '0;
        if (hit) begin
            case (ofs)
                OFS_PENDING: io.io_rdata = {8'h00, pending_q};
                OFS_MASK:    io.io_rdata = {8'h00, mask_q};
`ifdef IRQ_TIMER_EN
                OFS_RELOAD:  io.io_rdata = reload_q;
                OFS_COUNT:   io.io_rdata = count_q;
`endif
                default:     io.io_rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (default build; timer steps when IRQ_TIMER_EN).
module tb_irq_controller;
    localparam logic [15:0] BASE = 16'h0100;
    localparam logic [15:0] A_PEND = BASE + 16'h0;
    localparam logic [15:0] A_MASK = BASE + 16'h2;
    localparam logic [15:0] A_FORC = BASE + 16'h4;
    localparam logic [15:0] A_RELD = BASE + 16'h6;
    localparam logic [15:0] A_CNT  = BASE + 16'h8;

    logic       clk = 1'b0;
    logic       resetq;
    logic [7:0] irq_in;
    logic [7:0] int_rqst;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] rd;

    irq_controller_if bus ();

    irq_controller #(.ADDR_BASE(BASE), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .irq_in   (irq_in),
        .int_rqst (int_rqst),
        .io       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.io_addr  = addr;
        bus.io_wdata = data;
        bus.io_wr    = 1'b1;
        @(negedge clk);
        bus.io_wr    = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] addr, output logic [15:0] data);
        bus.io_addr = addr;
        #1 data = bus.io_rdata;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetq       = 1'b0;
        irq_in       = 8'h00;
        bus.io_addr  = 16'h0000;
        bus.io_wr    = 1'b0;
        bus.io_rd    = 1'b0;
        bus.io_wdata = 16'h0000;

        // Reset state
        #12;
        check("rst_rqst", {8'h00, int_rqst}, 16'h0000);
        io_read(A_PEND, rd); check("rst_pend", rd, 16'h0000);
        io_read(A_MASK, rd); check("rst_mask", rd, 16'h0000);
        @(negedge clk);
        resetq = 1'b1;
        wait_clks(2);

        // 1: rising edge on irq_in[3], two-edge latency, no re-trigger while held
        io_write(A_MASK, 16'h00FF);
        irq_in = 8'h08;
        @(posedge clk); @(negedge clk);
        check("t1_lat_n", {8'h00, int_rqst}, 16'h0000);
        @(posedge clk); @(negedge clk);
        check("t1_lat_n1", {8'h00, int_rqst}, 16'h0000);
        @(posedge clk); @(negedge clk);
        check("t1_rqst", {8'h00, int_rqst}, 16'h0008);
        io_read(A_PEND, rd); check("t1_pend", rd, 16'h0008);
        io_write(A_PEND, 16'h0008);
        wait_clks(20);
        io_read(A_PEND, rd); check("t1_hold_pend", rd, 16'h0000);
        check("t1_hold_rqst", {8'h00, int_rqst}, 16'h0000);

        // 2: FORCE, priority, W1C, masking
        io_write(A_FORC, 16'h0081);
        check("t2_rqst80", {8'h00, int_rqst}, 16'h0080);
        io_write(A_PEND, 16'h0080);
        check("t2_rqst01", {8'h00, int_rqst}, 16'h0001);
        io_write(A_MASK, 16'h00FE);
        check("t2_masked", {8'h00, int_rqst}, 16'h0000);
        io_read(A_PEND, rd); check("t2_pend", rd, 16'h0001);
        io_write(A_PEND, 16'h0001);
        io_write(A_MASK, 16'h00FF);

        // 3: edge and W1C on the same clock -> set wins
        irq_in = 8'h00;
        wait_clks(4);
        irq_in = 8'h04;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.io_addr  = A_PEND;
        bus.io_wdata = 16'h0004;
        bus.io_wr    = 1'b1;
        @(negedge clk);
        bus.io_wr    = 1'b0;
        io_read(A_PEND, rd); check("t3_set_wins", rd, 16'h0004);
        check("t3_rqst", {8'h00, int_rqst}, 16'h0004);
        io_write(A_PEND, 16'h0004);
        io_read(A_PEND, rd); check("t3_cleared", rd, 16'h0000);
        irq_in = 8'h00;
        wait_clks(4);

        // Priority with partial mask
        io_write(A_FORC, 16'h0024);
        check("pri_rqst20", {8'h00, int_rqst}, 16'h0020);
        io_write(A_MASK, 16'h000F);
        check("pri_rqst04", {8'h00, int_rqst}, 16'h0004);

        // 5: unmapped / out-of-window accesses
        io_write(BASE + 16'h0010, 16'h00FF);
        io_write(BASE + 16'h000A, 16'h00FF);
        io_write(16'h0202, 16'h00FF);
        io_read(A_MASK, rd); check("t5_mask", rd, 16'h000F);
        io_read(A_PEND, rd); check("t5_pend", rd, 16'h0024);
        check("t5_rqst", {8'h00, int_rqst}, 16'h0004);
        io_read(BASE + 16'h0010, rd); check("t5_rd_10", rd, 16'h0000);
        io_read(BASE + 16'h000A, rd); check("t5_rd_0a", rd, 16'h0000);
        io_read(A_FORC, rd); check("t5_rd_force", rd, 16'h0000);
        io_write(A_PEND, 16'h00FF);
        io_read(A_PEND, rd); check("t5_clr_all", rd, 16'h0000);

`ifdef IRQ_TIMER_EN
        // 4: timer period 5 on source 7
        io_write(A_MASK, 16'h0080);
        irq_in = 8'h80;
        wait_clks(4);
        io_read(A_PEND, rd); check("t4_irq7_ignored", rd, 16'h0000);
        irq_in = 8'h00;
        io_write(A_RELD, 16'h0005);
        io_read(A_CNT, rd); check("t4_cnt5", rd, 16'h0005);
        for (int v = 4; v >= 1; v--) begin
            @(posedge clk); @(negedge clk);
            io_read(A_CNT, rd); check("t4_cnt", rd, 16'(v));
            io_read(A_PEND, rd); check("t4_pend_lo", rd, 16'h0000);
        end
        @(posedge clk); @(negedge clk);
        io_read(A_CNT, rd); check("t4_cnt_rel", rd, 16'h0005);
        io_read(A_PEND, rd); check("t4_pend_hi", rd, 16'h0080);
        check("t4_rqst", {8'h00, int_rqst}, 16'h0080);
        io_write(A_RELD, 16'h0000);
        io_write(A_PEND, 16'h0080);
        wait_clks(10);
        io_read(A_PEND, rd); check("t4_stopped", rd, 16'h0000);
        io_read(A_CNT, rd); check("t4_cnt0", rd, 16'h0000);
        io_write(A_RELD, 16'h0003);
`else
        // Source 7 comes from irq_in[7]; timer registers absent
        irq_in = 8'h80;
        wait_clks(3);
        io_read(A_PEND, rd); check("irq7_pend", rd, 16'h0080);
        irq_in = 8'h00;
        io_write(A_PEND, 16'h0080);
        io_write(A_RELD, 16'h0005);
        io_read(A_RELD, rd); check("no_reload", rd, 16'h0000);
        io_read(A_CNT, rd); check("no_count", rd, 16'h0000);
`endif

        // 6: asynchronous reset mid-operation
        io_write(A_MASK, 16'h00FF);
        io_write(A_FORC, 16'h00FF);
        check("t6_pre_rqst", {8'h00, int_rqst}, 16'h0080);
        @(negedge clk);
        #2 resetq = 1'b0;
        #1 check("t6_rqst", {8'h00, int_rqst}, 16'h0000);
        io_read(A_PEND, rd); check("t6_pend", rd, 16'h0000);
        io_read(A_MASK, rd); check("t6_mask", rd, 16'h0000);
`ifdef IRQ_TIMER_EN
        io_read(A_RELD, rd); check("t6_reload", rd, 16'h0000);
        io_read(A_CNT, rd); check("t6_count", rd, 16'h0000);
`endif
        @(negedge clk);
        resetq = 1'b1;
        wait_clks(2);
        check("t6_post_rqst", {8'h00, int_rqst}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
